// File: rtl/mips_decls_p.sv
// -----------------------------------------------------------------------------
// mips_decls_p
// Shared declarations for the instruction-fetch stage and the decode-stage
// controller: instruction field types, the NOP encoding and the fetch FSM
// state enum.
// -----------------------------------------------------------------------------
package mips_decls_p;

   typedef logic [5:0] opcode_t;   // instr[31:26]
   typedef logic [5:0] funct_t;    // instr[5:0]

   // All-zero word (sll $0,$0,0) used as the bubble instruction.
   localparam logic [31:0] NOP = 32'h0000_0000;

   // FETCH : request presented for pc_f
   // WAIT  : request in flight, address held
   // DROP  : waiting out the response to a squashed request
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pcnext_sel.sv
// -----------------------------------------------------------------------------
// pcnext_sel
// Combinational next-PC selection for the fetch stage.
//   pc_f, pcplus4_f      : current PC and its sequential successor
//   stall_d              : hazard hold; suppresses redirects and advancing
//   pcsrc, jump, jumpr   : redirect requests (priority jumpr > jump > pcsrc)
//   branch_target,
//   jump_target,
//   jr_target            : redirect addresses (bits [1:0] forced to zero)
//   advance              : a fetched or buffered word is entering IF/ID
//   redirect             : a redirect is being honoured this cycle
//   pc_next              : value pc_f takes at the next clock edge
// -----------------------------------------------------------------------------
module pcnext_sel (
   input  logic [31:0] pc_f,
   input  logic [31:0] pcplus4_f,
   input  logic        stall_d,
   input  logic        pcsrc,
   input  logic        jump,
   input  logic        jumpr,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   input  logic        advance,
   output logic        redirect,
   output logic [31:0] pc_next
);

   always_comb begin
      // NOTE: every output gets a value before any branch, so no path
      // through the block leaves one unassigned and no latch is inferred.
      redirect = ~stall_d & (jumpr | jump | pcsrc);
      pc_next  = pc_f;
      if (redirect) begin
         if (jumpr) begin
            pc_next = jr_target;
         end else if (jump) begin
            pc_next = jump_target;
         end else begin
            pc_next = branch_target;
         end
         pc_next[1:0] = 2'b00;   // instructions are word aligned
      end else if (advance && !stall_d) begin
         pc_next = pcplus4_f;    // wraps modulo 2^32
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: PC register, instruction-memory request/ack
// handshake, one-entry hold buffer for words returned while decode is
// stalled, and the IF/ID pipeline register.
//
// Parameter
//   RESET_VECTOR : PC value loaded while reset_n is low
// Ports
//   clk, reset_n                  : clock, asynchronous active-low reset
//   stall_d                       : hazard unit holds IF/ID and the PC
//   pcsrc, jump, jumpr            : redirect requests from decode
//   branch_target, jump_target,
//   jr_target                     : redirect addresses
//   imem_req, imem_addr           : instruction-memory request (addr = pc_f)
//   imem_ack, imem_rdata          : instruction-memory response
//   instr_d, pcplus4_d, valid_d   : IF/ID register
//   opcode_d, funct_d             : instr_d fields for the controller
//
// Build option
//   FETCH_IMEM_WAIT_EN : honour imem_ack with the WAIT/DROP states. Without
//                        it the memory is single-cycle combinational and
//                        imem_ack is ignored (treated as always 1).
// -----------------------------------------------------------------------------
module fetch_unit
   import mips_decls_p::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall_d,
   input  logic        pcsrc,
   input  logic        jump,
   input  logic        jumpr,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pcplus4_d,
   output logic        valid_d,
   output opcode_t     opcode_d,
   output funct_t      funct_d
);

   fetch_state_t state_q, state_n;
   logic [31:0]  pc_f, pc_next, pcplus4_f;
   logic         started_q;      // low for the first cycle after reset
   logic         hold_valid_q;
   logic [31:0]  hold_data_q;
   logic         ack, accept, drain, redirect;

`ifdef FETCH_IMEM_WAIT_EN
   assign ack = imem_ack;
`else
   logic unused_imem_ack;
   assign unused_imem_ack = imem_ack;
   assign ack             = 1'b1;
`endif

   assign pcplus4_f = pc_f + 32'd4;
   assign imem_addr = pc_f;
   // No request while a buffered word is pending (including the cycle it
   // drains) or while a squashed response is still owed.
   assign imem_req  = started_q & ~hold_valid_q & (state_q != DROP);
   assign accept    = imem_req & ack;          // word for pc_f is on imem_rdata
   assign drain     = hold_valid_q & ~stall_d;

   assign opcode_d  = instr_d[31:26];
   assign funct_d   = instr_d[5:0];

   pcnext_sel u_pcnext_sel (
      .pc_f          (pc_f),
      .pcplus4_f     (pcplus4_f),
      .stall_d       (stall_d),
      .pcsrc         (pcsrc),
      .jump          (jump),
      .jumpr         (jumpr),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
      .advance       (accept | drain),
      .redirect      (redirect),
      .pc_next       (pc_next)
   );

   // A redirect in FETCH retargets the request before the memory has
   // committed to it; only a WAIT-state request is known to be in flight
   // and must have its response thrown away in DROP.
   always_comb begin
      state_n = state_q;
`ifdef FETCH_IMEM_WAIT_EN
      case (state_q)
         FETCH, WAIT: begin
            if (imem_req) begin
               if (ack) begin
                  state_n = FETCH;
               end else if (redirect && state_q == WAIT) begin
                  state_n = DROP;
               end else begin
                  state_n = WAIT;
               end
            end
         end
         DROP: begin
            if (ack) begin
               state_n = FETCH;
            end
         end
         default: state_n = FETCH;
      endcase
`else
      state_n = FETCH;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         state_q      <= FETCH;
         pc_f         <= RESET_VECTOR;
         started_q    <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= NOP;
         valid_d      <= 1'b0;
         instr_d      <= NOP;
         pcplus4_d    <= 32'h0000_0000;
      end else begin
         state_q   <= state_n;
         pc_f      <= pc_next;
         started_q <= 1'b1;
         if (stall_d) begin
            // IF/ID and pc_f hold; a word arriving now waits in the buffer.
            if (accept) begin
               hold_valid_q <= 1'b1;
               hold_data_q  <= imem_rdata;
            end
         end else if (redirect) begin
            // Flush: same-cycle ack data and any buffered word are discarded.
            hold_valid_q <= 1'b0;
            valid_d      <= 1'b0;
            instr_d      <= NOP;
         end else if (drain) begin
            hold_valid_q <= 1'b0;
            instr_d      <= hold_data_q;
            pcplus4_d    <= pcplus4_f;
            valid_d      <= 1'b1;
         end else if (accept) begin
            instr_d   <= imem_rdata;
            pcplus4_d <= pcplus4_f;
            valid_d   <= 1'b1;
         end else begin
            valid_d <= 1'b0;
            instr_d <= NOP;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (RESET_VECTOR = 0x400). A reference model of
// the fetch stage is advanced once per clock from the applied inputs and a
// compare process checks the DUT against it on every falling edge; literal
// expectations at key points pin the model. The memory returns a fixed
// function of the requested address. Wait-state scenarios are compiled only
// when FETCH_IMEM_WAIT_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
   import mips_decls_p::*;

   localparam logic [31:0] RV = 32'h0000_0400;
`ifdef FETCH_IMEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall_d = 1'b0, pcsrc = 1'b0, jump = 1'b0, jumpr = 1'b0;
   logic [31:0] branch_target = '0, jump_target = '0, jr_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata;
   logic [31:0] instr_d, pcplus4_d;
   logic        valid_d;
   opcode_t     opcode_d;
   funct_t      funct_d;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_VECTOR(RV)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall_d       (stall_d),
      .pcsrc         (pcsrc),
      .jump          (jump),
      .jumpr         (jumpr),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_d       (instr_d),
      .pcplus4_d     (pcplus4_d),
      .valid_d       (valid_d),
      .opcode_d      (opcode_d),
      .funct_d       (funct_d)
   );

   always #5 clk = ~clk;

   // Instruction memory contents as a function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:2] ^ 6'h23, a[15:8] ^ 8'h5A, 12'hC0F, a[7:2]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pc = RV, m_instr = '0, m_pc4 = '0;
   logic        m_valid = 1'b0, m_started = 1'b0;
   logic        m_inflight = 1'b0;   // request outstanding from an earlier cycle
   logic        m_owed = 1'b0;       // a squashed response still to arrive
   logic [31:0] m_hold[$];

   task automatic model_reset();
      m_pc = RV; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
      m_started = 1'b0; m_inflight = 1'b0; m_owed = 1'b0;
      m_hold.delete();
   endtask

   // Effect of one rising edge given the inputs currently applied.
   task automatic model_step();
      logic        ack_e, req, got, redir;
      logic [31:0] tgt;
      ack_e = WAIT_EN ? imem_ack : 1'b1;
      req   = m_started && (m_hold.size() == 0) && !m_owed;
      got   = req && ack_e;
      redir = !stall_d && (pcsrc || jump || jumpr);
      tgt   = jumpr ? jr_target : (jump ? jump_target : branch_target);
      tgt   = tgt & 32'hFFFF_FFFC;

      if (m_owed) begin
         m_owed = !ack_e;
      end else if (req && !ack_e) begin
         if (redir && m_inflight) begin
            m_owed = 1'b1; m_inflight = 1'b0;
         end else begin
            m_inflight = 1'b1;
         end
      end else begin
         m_inflight = 1'b0;
      end

      if (stall_d) begin
         if (got) m_hold.push_back(mem_word(m_pc));
      end else if (redir) begin
         m_pc = tgt; m_valid = 1'b0; m_instr = '0; m_hold.delete();
      end else if (m_hold.size() != 0) begin
         m_instr = m_hold.pop_front(); m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_valid = 1'b1;
      end else if (got) begin
         m_instr = mem_word(m_pc); m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_valid = 1'b1;
      end else begin
         m_valid = 1'b0; m_instr = '0;
      end
      m_started = 1'b1;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      check("cmp_req",    32'(imem_req), 32'(m_started && (m_hold.size() == 0) && !m_owed));
      check("cmp_addr",   imem_addr, m_pc);
      check("cmp_valid",  32'(valid_d), 32'(m_valid));
      check("cmp_instr",  instr_d, m_instr);
      check("cmp_opcode", 32'(opcode_d), 32'(m_instr[31:26]));
      check("cmp_funct",  32'(funct_d), 32'(m_instr[5:0]));
      if (m_valid) check("cmp_pc4", pcplus4_d, m_pc4);
   end

   // One clock: apply {stall_d, pcsrc, jump, jumpr, imem_ack}, step the model
   // at the edge, return just after it.
   task automatic cyc(input logic [4:0] v);
      {stall_d, pcsrc, jump, jumpr, imem_ack} = v;
      @(posedge clk);
      model_step();
      #1;
   endtask

   logic [4:0] walk [16] = '{5'b00001, 5'b00000, 5'b10001, 5'b10000,
                             5'b00001, 5'b01000, 5'b00000, 5'b00001,
                             5'b00101, 5'b10001, 5'b00011, 5'b00000,
                             5'b00001, 5'b10011, 5'b00001, 5'b00001};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_req",   32'(imem_req), 32'd0);
      check("reset_addr",  imem_addr, 32'h0000_0400);
      check("reset_valid", 32'(valid_d), 32'd0);
      check("reset_instr", instr_d, 32'd0);
      check("reset_pc4",   pcplus4_d, 32'd0);

      // Reset release, ack every cycle.
      reset_n = 1'b1;
      cyc(5'b00001);
      check("first_req",   32'(imem_req), 32'd1);
      check("first_addr",  imem_addr, 32'h0000_0400);
      check("first_valid", 32'(valid_d), 32'd0);
      cyc(5'b00001);
      check("seq_addr1",   imem_addr, 32'h0000_0404);
      check("seq_valid1",  32'(valid_d), 32'd1);
      check("seq_instr1",  instr_d, 32'h8D7B_03C0);
      check("seq_pc4_1",   pcplus4_d, 32'h0000_0404);
      cyc(5'b00001);
      check("seq_addr2",   imem_addr, 32'h0000_0408);
      check("seq_instr2",  instr_d, 32'h897B_03C1);

      // jumpr beats jump beats pcsrc.
      jr_target = 32'h200; jump_target = 32'h300; branch_target = 32'h100;
      cyc(5'b01111);
      check("prio_addr",   imem_addr, 32'h0000_0200);
      check("prio_valid",  32'(valid_d), 32'd0);
      cyc(5'b00001);
      check("prio_instr",  instr_d, 32'h8D63_03C0);
      jump_target = 32'h303;
      cyc(5'b01101);
      check("jmp_align",   imem_addr, 32'h0000_0300);
      branch_target = 32'h82;
      cyc(5'b01001);
      check("br_align",    imem_addr, 32'h0000_0080);
      cyc(5'b00001);
      check("br_instr",    instr_d, 32'h0D6B_03E0);

      // Ack during a two-cycle stall; a redirect while stalled is ignored.
      cyc(5'b10001);
      check("stall_instr", instr_d, 32'h0D6B_03E0);
      check("stall_pc4",   pcplus4_d, 32'h0000_0084);
      check("stall_addr",  imem_addr, 32'h0000_0084);
      check("stall_req",   32'(imem_req), 32'd0);
      cyc(5'b11000);
      check("stall2_addr", imem_addr, 32'h0000_0084);
      check("drain_req",   32'(imem_req), 32'd0);
      cyc(5'b00001);
      check("drain_instr", instr_d, 32'h897B_03E1 ^ 32'h0000_0000 ^ (32'h897B_03E1 ^ mem_word(32'h84)));
      check("drain_pc4",   pcplus4_d, 32'h0000_0088);
      check("drain_addr",  imem_addr, 32'h0000_0088);

      // PC wraps past the top of the address space.
      jr_target = 32'hFFFF_FFFC;
      cyc(5'b00011);
      check("wrap_pre",    imem_addr, 32'hFFFF_FFFC);
      cyc(5'b00001);
      check("wrap_addr",   imem_addr, 32'h0000_0000);
      check("wrap_pc4",    pcplus4_d, 32'h0000_0000);

`ifdef FETCH_IMEM_WAIT_EN
      // Ack delayed three cycles.
      jr_target = 32'h400;
      cyc(5'b00011);
      cyc(5'b00001);
      for (int i = 0; i < 3; i++) begin
         cyc(5'b00000);
         check("dly_addr",  imem_addr, 32'h0000_0404);
         check("dly_valid", 32'(valid_d), 32'd0);
      end
      cyc(5'b00001);
      check("dly_instr",   instr_d, 32'h897B_03C1);
      check("dly_addr2",   imem_addr, 32'h0000_0408);

      // Branch while a request is in flight: stale response dropped.
      cyc(5'b00000);
      branch_target = 32'h80;
      cyc(5'b01000);
      check("drop_addr",   imem_addr, 32'h0000_0080);
      check("drop_req",    32'(imem_req), 32'd0);
      cyc(5'b00000);
      cyc(5'b00001);
      check("drop_valid",  32'(valid_d), 32'd0);
      check("drop_req2",   32'(imem_req), 32'd1);
      cyc(5'b00001);
      check("drop_instr",  instr_d, 32'h0D6B_03E0);
      check("drop_next",   imem_addr, 32'h0000_0084);
`endif

      // Mixed walk.
      branch_target = 32'h1000; jump_target = 32'h2004; jr_target = 32'h3008;
      foreach (walk[i]) cyc(walk[i]);

      // Reset asserted with a request outstanding.
      cyc(5'b00000);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_req",   32'(imem_req), 32'd0);
      check("mid_rst_addr",  imem_addr, 32'h0000_0400);
      check("mid_rst_valid", 32'(valid_d), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc(5'b00001);
      check("rel_req",     32'(imem_req), 32'd1);
      check("rel_addr",    imem_addr, 32'h0000_0400);
      cyc(5'b00001);
      check("rel_instr",   instr_d, 32'h8D7B_03C0);
      check("rel_addr2",   imem_addr, 32'h0000_0404);
      cyc(5'b00001);
      @(negedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port stall_d, input, 1, meaning the hazard unit holds the IF/ID register and PC.
REQ-005 SHALL have ports pcsrc, jump and jumpr, each input, 1, meaning redirect requests from the decode-stage controller.
REQ-006 SHALL have ports branch_target, jump_target and jr_target, each input, 32, meaning the redirect addresses.
REQ-007 SHALL have ports imem_req (output, 1), imem_addr (output, 32), imem_ack (input, 1) and imem_rdata (input, 32), forming the instruction-memory handshake.
REQ-008 SHALL have ports instr_d (output, 32), pcplus4_d (output, 32) and valid_d (output, 1), forming the IF/ID register.
REQ-009 SHALL have ports opcode_d (output, mips_decls_p::opcode_t, instr_d[31:26]) and funct_d (output, mips_decls_p::funct_t, instr_d[5:0]), feeding the controller.

Function
REQ-010 SHALL hold PC register pc_f; imem_addr = pc_f at all times.
REQ-011 SHALL implement FSM with states FETCH, WAIT and DROP.
- FETCH: imem_req=1.
- WAIT: request outstanding, imem_req=1, imem_addr stable.
- DROP: discard the response to a squashed request, imem_req=0.
REQ-012 SHALL follow these FSM transitions.
- FETCH/WAIT with imem_ack=1 -> FETCH.
- FETCH/WAIT with imem_ack=0 -> WAIT.
- WAIT with redirect and imem_ack=0 -> DROP.
- DROP with imem_ack=1 -> FETCH.
REQ-013 SHALL select the redirect target with priority jumpr > jump > pcsrc; a redirect is honoured only when stall_d=0.
REQ-014 SHALL, on a honoured redirect, set pc_f to the selected target, clear valid_d next cycle (flush), and discard any same-cycle imem_ack data.
REQ-015 SHALL, on imem_ack=1 in FETCH/WAIT with stall_d=0 and no redirect, set pc_f <= pc_f+4, instr_d <= imem_rdata, pcplus4_d <= pc_f+4 and valid_d <= 1.
REQ-016 SHALL, on stall_d=0 with no accepted fetch, load valid_d <= 0 (bubble) and set instr_d to the all-zero NOP.
REQ-017 SHALL, on stall_d=1, hold instr_d, pcplus4_d, valid_d and pc_f unchanged.
REQ-018 SHALL, if imem_ack arrives during stall_d=1, capture the word in a one-entry hold buffer and issue no new request until it drains.
REQ-019 SHALL drain the hold buffer into IF/ID on the first cycle with stall_d=0, with no imem access that cycle.
REQ-020 SHALL clear the hold buffer on a redirect.
REQ-021 SHALL compute PC arithmetic modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0; bits [1:0] of any target are forced to 0.

Reset
REQ-022 SHALL, while reset_n=0, set pc_f=RESET_VECTOR, FSM=FETCH, valid_d=0, instr_d=0, pcplus4_d=0, hold buffer empty and imem_req=0.
REQ-023 SHALL issue its first request on the first clock edge after reset_n rises.
REQ-024 SHALL abandon any outstanding request when reset is asserted mid-operation, with no DROP state entered.

Configuration
REQ-025 SHALL, with macro FETCH_IMEM_WAIT_EN defined, honour imem_ack exactly as above.
REQ-026 SHALL, without FETCH_IMEM_WAIT_EN, treat imem_ack as constant 1 and omit states WAIT and DROP, giving a single-cycle combinational imem.

Structure
REQ-027 SHALL place opcode_t, funct_t, the NOP constant and a fetch-state enum in package mips_decls_p.
REQ-028 SHALL implement next-PC priority selection in combinational sub-module pcnext_sel.

Verification
REQ-029 SHALL cover reset release with RESET_VECTOR=32'h400 and ack every cycle -> imem_addr sequence 0x400, 0x404, 0x408, and valid_d=1 from cycle 2.
REQ-030 SHALL cover ack delayed 3 cycles -> imem_addr held at 0x404, valid_d=0 for 3 cycles, then instr_d=rdata.
REQ-031 SHALL cover pcsrc=1 with branch_target=0x80 while in WAIT, ack 2 cycles later -> the stale word is dropped, the next fetch is at 0x80, and valid_d=0 for one cycle.
REQ-032 SHALL cover jumpr=1 and jump=1 together with jr_target=0x200 and jump_target=0x300 -> pc_f=0x200.
REQ-033 SHALL cover stall_d=1 for 2 cycles with an ack arriving -> IF/ID unchanged; after release instr_d=buffered word and no extra imem request.
REQ-034 SHALL cover pc_f=0xFFFF_FFFC with an ack -> next imem_addr=0x0.
